// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared definitions for the byte-wide MMIO bus: initiator FSM states,
// access-size encoding, beat-count and load-extension helpers, and the
// GPIO responder address map used by both initiator-side software models
// and the responders themselves.
package mmio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } mmio_init_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mmio_size_e;

   // GPIO responder map: output register at base, input register at base+4.
   localparam logic [31:0] GPIO_BASE     = 32'h2000_0000;
   localparam logic [31:0] GPIO_OUT_OFS  = 32'h0000_0000;
   localparam logic [31:0] GPIO_IN_OFS   = 32'h0000_0004;
   localparam logic [31:0] GPIO_OUT_ADDR = GPIO_BASE + GPIO_OUT_OFS;
   localparam logic [31:0] GPIO_IN_ADDR  = GPIO_BASE + GPIO_IN_OFS;

   // Raw size code 3 has no meaning of its own and is folded onto WORD.
   function automatic mmio_size_e mmio_decode_size(input logic [1:0] raw);
      mmio_size_e sz;
      case (raw)
         2'd0:    sz = SZ_BYTE;
         2'd1:    sz = SZ_HALF;
         default: sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic [2:0] mmio_nbeats(input mmio_size_e size);
      logic [2:0] n;
      case (size)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   // Keep the low bytes of a little-endian accumulator and zero- or
   // sign-extend them to 32 bits.
   function automatic logic [31:0] mmio_extend(input logic [31:0] data,
                                               input mmio_size_e  size,
                                               input logic        sgn);
      logic [31:0] r;
      case (size)
         SZ_BYTE: r = {{24{sgn & data[7]}},  data[7:0]};
         SZ_HALF: r = {{16{sgn & data[15]}}, data[15:0]};
         default: r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mmio_byte_initiator.sv
// mmio_byte_initiator
// Turns one byte/half/word load-store request into consecutive little-endian
// byte beats on the MMIO bus and returns a single-cycle completion with the
// extended load data.
//
// Ports
//   i_clk, i_rstn          clock, synchronous active-low reset
//   i_req_valid/o_req_ready request handshake (ready only in IDLE)
//   i_req_addr/we/size/signed/wdata  request fields, latched on accept
//   o_rsp_valid/o_rsp_rdata one-cycle completion, rdata 0 for stores
//   o_mmio_addr/data_out/we/re beat outputs, decoded from registered state
//   i_mmio_data_in         responder read byte, sampled in load beats
module mmio_byte_initiator
   import mmio_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic                  i_req_we,
   input  logic [1:0]            i_req_size,
   input  logic                  i_req_signed,
   input  logic [31:0]           i_req_wdata,
   output logic                  o_rsp_valid,
   output logic [31:0]           o_rsp_rdata,
   output logic [ADDR_WIDTH-1:0] o_mmio_addr,
   output logic [7:0]            o_mmio_data_out,
   input  logic [7:0]            i_mmio_data_in,
   output logic                  o_mmio_we,
   output logic                  o_mmio_re
);

   mmio_init_state_e      state_q,  state_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic                  we_q,     we_d;
   mmio_size_e            size_q,   size_d;
   logic                  sgn_q,    sgn_d;
   logic [31:0]           wdata_q,  wdata_d;
   logic [2:0]            nbeats_q, nbeats_d;
   logic [1:0]            cnt_q,    cnt_d;
   logic [31:0]           acc_q,    acc_d;

   logic [4:0]            lane;
   logic                  last_beat;

   assign lane      = {cnt_q, 3'b000};
   assign last_beat = ({1'b0, cnt_q} == (nbeats_q - 3'd1));

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      we_d            = we_q;
      size_d          = size_q;
      sgn_d           = sgn_q;
      wdata_d         = wdata_q;
      nbeats_d        = nbeats_q;
      cnt_d           = cnt_q;
      acc_d           = acc_q;

      o_req_ready     = 1'b0;
      o_rsp_valid     = 1'b0;
      o_rsp_rdata     = '0;
      o_mmio_addr     = '0;
      o_mmio_data_out = '0;
      o_mmio_we       = 1'b0;
      o_mmio_re       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               addr_d   = i_req_addr;
               we_d     = i_req_we;
               size_d   = mmio_decode_size(i_req_size);
               sgn_d    = i_req_signed;
               wdata_d  = i_req_wdata;
               nbeats_d = mmio_nbeats(mmio_decode_size(i_req_size));
               cnt_d    = '0;
               acc_d    = '0;
               state_d  = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            // Address wraps naturally at the ADDR_WIDTH boundary.
            o_mmio_addr = addr_q + ADDR_WIDTH'(cnt_q);
            if (we_q) begin
               o_mmio_we       = 1'b1;
               o_mmio_data_out = wdata_q[lane +: 8];
            end else begin
               o_mmio_re        = 1'b1;
               acc_d[lane +: 8] = i_mmio_data_in;
            end
            if (last_beat) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         ST_RESP: begin
            o_rsp_valid = 1'b1;
            o_rsp_rdata = we_q ? '0 : mmio_extend(acc_q, size_q, sgn_q);
            state_d     = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         size_q   <= SZ_BYTE;
         sgn_q    <= 1'b0;
         wdata_q  <= '0;
         nbeats_q <= 3'd1;
         cnt_q    <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         size_q   <= size_d;
         sgn_q    <= sgn_d;
         wdata_q  <= wdata_d;
         nbeats_q <= nbeats_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: tb/tb_mmio_byte_initiator.sv
module tb_mmio_byte_initiator;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [31:0] mmio_addr;
   logic [7:0]  mmio_dout;
   logic [7:0]  mmio_din;
   logic        mmio_we;
   logic        mmio_re;

   logic [7:0]  mem [256];

   int n_cmp = 0;
   int n_err = 0;
   int rsp_seen = 0;
   int rsp_exp  = 0;

   // held request presented while the DUT is busy
   logic [31:0] h_addr;
   logic        h_we;
   logic [1:0]  h_size;
   logic        h_signed;
   logic [31:0] h_wdata;

   always #5 clk = ~clk;

   mmio_byte_initiator #(.ADDR_WIDTH(32)) dut (
      .i_clk          (clk),
      .i_rstn         (rstn),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_addr     (req_addr),
      .i_req_we       (req_we),
      .i_req_size     (req_size),
      .i_req_signed   (req_signed),
      .i_req_wdata    (req_wdata),
      .o_rsp_valid    (rsp_valid),
      .o_rsp_rdata    (rsp_rdata),
      .o_mmio_addr    (mmio_addr),
      .o_mmio_data_out(mmio_dout),
      .i_mmio_data_in (mmio_din),
      .o_mmio_we      (mmio_we),
      .o_mmio_re      (mmio_re)
   );

   // Combinational responder: byte memory indexed by low address byte.
   always_comb mmio_din = mem[mmio_addr[7:0]];

   always @(posedge clk) if (rsp_valid === 1'b1) rsp_seen++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_rspv"},  {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_addr"},  mmio_addr, 32'd0);
      chk({tag, "_dout"},  {24'd0, mmio_dout}, 32'd0);
      chk({tag, "_we"},    {31'd0, mmio_we}, 32'd0);
      chk({tag, "_re"},    {31'd0, mmio_re}, 32'd0);
   endtask

   // Expected load result from the specification: assemble little-endian
   // bytes, then sign-extend by subtracting 2^(8n) when the top bit is set.
   function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input logic sg);
      longint v = 0;
      logic [31:0] ba;
      for (int k = 0; k < nb; k++) begin
         ba = a + k;
         v = v + (longint'(mem[ba[7:0]]) << (8 * k));
      end
      if (sg && ((v >> (8 * nb - 1)) & 1) == 1) v = v - (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction

   // Called at a negedge. Returns at the negedge where ready is high again.
   task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd, input bit hold);
      int nb;
      int guard;
      logic [31:0] exp_rd;
      logic [31:0] ba;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      req_valid  = 1'b1;
      req_addr   = a;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_wdata  = wd;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         req_addr   = h_addr;
         req_we     = h_we;
         req_size   = h_size;
         req_signed = h_signed;
         req_wdata  = h_wdata;
      end else begin
         req_valid = 1'b0;
      end
      exp_rd = we ? 32'd0 : ref_load(a, nb, sg);
      for (int k = 0; k < nb; k++) begin
         ba = a + k;
         chk("beat_addr",  mmio_addr, ba);
         chk("beat_we",    {31'd0, mmio_we}, {31'd0, we});
         chk("beat_re",    {31'd0, mmio_re}, {31'd0, ~we});
         chk("beat_dout",  {24'd0, mmio_dout}, we ? ((wd >> (8 * k)) & 32'hFF) : 32'd0);
         chk("beat_ready", {31'd0, req_ready}, 32'd0);
         chk("beat_rspv",  {31'd0, rsp_valid}, 32'd0);
         @(negedge clk);
      end
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_strobes", {30'd0, mmio_we, mmio_re}, 32'd0);
      chk("rsp_ready", {31'd0, req_ready}, 32'd0);
      rsp_exp++;
      @(negedge clk);
      chk("post_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rspv",  {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      rstn = 1'b0;
      req_valid = 1'b0;
      req_addr = '0; req_we = 1'b0; req_size = '0; req_signed = 1'b0; req_wdata = '0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      chk_idle_outputs("reset");

      // byte store, word store
      do_req(32'h2000_0000, 1'b1, 2'd0, 1'b0, 32'hDEAD_BEA5, 1'b0);
      do_req(32'h2000_0000, 1'b1, 2'd2, 1'b0, 32'h1122_3344, 1'b0);

      // signed and unsigned byte load of 0x80
      mem[8'h04] = 8'h80;
      do_req(32'h2000_0004, 1'b0, 2'd0, 1'b1, 32'h0, 1'b0);
      chk("sbyte_const", rsp_rdata, 32'd0);
      do_req(32'h2000_0004, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);

      // halfword load wrapping the address space
      mem[8'hFF] = 8'h34;
      mem[8'h00] = 8'h12;
      do_req(32'hFFFF_FFFF, 1'b0, 2'd1, 1'b1, 32'h0, 1'b0);

      // request held while a word load is busy, then accepted exactly once
      h_addr = 32'h0000_0040; h_we = 1'b1; h_size = 2'd1; h_signed = 1'b0; h_wdata = 32'h0000_BEEF;
      do_req(32'h0000_0010, 1'b0, 2'd2, 1'b1, 32'h0, 1'b1);
      do_req(h_addr, h_we, h_size, h_signed, h_wdata, 1'b0);
      repeat (3) begin
         chk("idle_after_hold", {30'd0, mmio_we, mmio_re}, 32'd0);
         @(negedge clk);
      end

      // reset during beat 2 of a word load
      req_valid = 1'b1; req_addr = 32'h0000_0080; req_we = 1'b0;
      req_size = 2'd2; req_signed = 1'b0; req_wdata = '0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_beat1_addr", mmio_addr, 32'h0000_0080);
      @(negedge clk);
      chk("rst_beat2_re",   {31'd0, mmio_re}, 32'd1);
      chk("rst_beat2_addr", mmio_addr, 32'h0000_0081);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk_idle_outputs("after_rst");
      repeat (4) begin
         @(negedge clk);
         chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
      end
      do_req(32'h0000_0055, 1'b0, 2'd0, 1'b1, 32'h0, 1'b0);

      // randomized requests, size 3 included
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         if (i % 5 == 0) ra[7:0] = 8'hFE;
         if ($urandom_range(0, 3) == 0) mem[8'($urandom)] = 8'($urandom);
         do_req(ra, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, 1'b0);
      end

      @(negedge clk);
      chk("rsp_pulse_count", rsp_seen, rsp_exp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
